seg_reader: RTL and testbench
=============================

# seg_reader

Reads a 7-segment character pattern from an active-low segment bus and converts it back into the 4-bit character code used by the board's letter display set, O L E G H I B P C. It is the decode-side counterpart of the switch-to-HEX letter decoder. It synchronises and debounces the bus, then emits one VALID pulse per distinct character. It keeps a four-character history and flags the sequence "OLEG" on MATCH.

## Interface
- STABLE_CYCLES, 4, consecutive synchronised cycles a pattern must hold before it qualifies; legal range 1..255.
- CLOCK_50  input  1  system clock, rising edge.
- KEY  input  [0:0]  KEY[0] is the asynchronous, active-low reset.
- SEG  input  [6:0]  segment pattern, active-low (0 = lit), SEG[0]=a … SEG[6]=g; asynchronous to CLOCK_50.
- CODE  output  [3:0]  last accepted character code.
- VALID  output  1  one-cycle pulse when CODE is updated.
- ERR  output  1  one-cycle pulse when an unknown pattern qualifies.
- MATCH  output  1  high while the last four accepted codes, oldest first, are 0,1,2,3.
- COUNT  output  [7:0]  number of accepted characters; saturates at 255.

## Operation
- Character table, pattern to code:
  - 0x40 → 0 (O)
  - 0x47 → 1 (L)
  - 0x06 → 2 (E)
  - 0x42 → 3 (G)
  - 0x09 → 4 (H)
  - 0x4F → 5 (I)
  - 0x00 → 6 (B)
  - 0x0C → 7 (P)
  - 0x46 → 8 (C)
- 0x7F is BLANK. Every other pattern is UNKNOWN.
- Input path:
  - SEG passes through a 2-flop synchroniser. Both flops reset to 0x7F.
  - The stability counter is 8 bits. It loads 1 when the sync output differs from its previous value. Otherwise it increments, saturating at STABLE_CYCLES.
  - A pattern qualifies once, on the cycle the counter first equals STABLE_CYCLES.
- Acceptance FSM, two states:
  - ARMED: a qualified known pattern is accepted. Then go to HELD, storing the pattern as last_pat.
  - HELD: a qualified known pattern equal to last_pat is ignored. A different known pattern is accepted and last_pat is updated.
  - BLANK qualified, from either state: go to ARMED. No pulse; no other change.
  - UNKNOWN qualified, from either state: pulse ERR, clear the history to 0xF entries, go to ARMED. CODE and COUNT hold.
- On acceptance:
  - CODE gets the decoded value and VALID pulses.
  - The history shifts: four 4-bit entries, newest in.
  - COUNT increments, saturating at 255.
  - MATCH is recomputed from the updated history.
- Reset (KEY[0]=0, asynchronous, valid at any time including mid-qualification):
  - Outputs: CODE=0, VALID=0, ERR=0, MATCH=0, COUNT=0.
  - Internal: history all 0xF, FSM in ARMED, counter 0, sync flops 0x7F.
  - No pulse may occur during reset or on the first edge after release.

## Timing
- All outputs are registered.
- Qualification latency: with SEG constant from before edge 1, the counter is 1 after edge 2 and equals STABLE_CYCLES after edge STABLE_CYCLES+1.
- VALID or ERR is high for exactly one cycle, following edge STABLE_CYCLES+2. For STABLE_CYCLES=4 that is after edge 6.
- CODE, COUNT and MATCH update on the same edge that raises VALID.
- Any change shorter than STABLE_CYCLES sync cycles never qualifies and produces no pulse.
- Back-to-back distinct characters can each be accepted at a rate of one per STABLE_CYCLES cycles.
- VALID and ERR are never high in the same cycle.

## Test plan
- Reset: hold SEG=0x40 and assert KEY[0]=0 on the cycle its qualification was due → all outputs 0 immediately, and no VALID after release until a new full hold completes.
- Latency: STABLE_CYCLES=4, SEG=0x40 held 12 cycles → exactly one VALID, after edge 6; CODE=0, COUNT=1, MATCH=0.
- Sequence: apply 0x40, 0x47, 0x06, 0x42, each held 8 cycles and separated by 8 cycles of 0x7F → CODE 0,1,2,3, COUNT=4, MATCH=1 from the fourth VALID. Then 0x09 → CODE=4, MATCH=0.
- Debounce: 0x40 accepted, then 0x06 for 2 cycles, then back to 0x40 → no further VALID, no ERR, COUNT unchanged.
- Repeats:
  - 0x47 held 20 cycles → one VALID.
  - 0x47, 0x7F, 0x47 → two VALIDs, COUNT +2.
  - 0x47 directly followed by 0x46 → VALID with CODE=8.
- Unknown: after "OLEG" (MATCH=1), apply 0x7E → ERR pulse, MATCH=0, CODE stays 3. Then "OLEG" again → MATCH=1 only after the fourth new acceptance.

Source files
------------

// File: rtl/seg_reader_if.sv
// seg_reader_if: segment bus and decoded-character outputs of seg_reader.
//   SEG   - active-low 7-segment pattern (SEG[0]=a .. SEG[6]=g), async to the reader clock
//   CODE  - last accepted character code
//   VALID - one-cycle pulse when CODE updates
//   ERR   - one-cycle pulse when an unknown pattern qualifies
//   MATCH - high while the last four accepted codes, oldest first, are 0,1,2,3
//   COUNT - accepted-character count, saturating at 255
// master drives SEG (the display side); slave is the reader.
interface seg_reader_if;
    logic [6:0] SEG;
    logic [3:0] CODE;
    logic       VALID;
    logic       ERR;
    logic       MATCH;
    logic [7:0] COUNT;

    modport master (
        output SEG,
        input  CODE,
        input  VALID,
        input  ERR,
        input  MATCH,
        input  COUNT
    );

    modport slave (
        input  SEG,
        output CODE,
        output VALID,
        output ERR,
        output MATCH,
        output COUNT
    );
endinterface

// File: rtl/seg_reader.sv
// seg_reader: decodes an active-low 7-segment letter pattern (O L E G H I B P C) back into its
// 4-bit character code. The bus is synchronised and debounced; each distinct character yields
// one VALID pulse, unknown patterns yield an ERR pulse, and a four-entry history raises MATCH
// while the sequence "OLEG" is the most recent one.
// Ports:
//   CLOCK_50 - system clock, rising edge
//   KEY[0]   - asynchronous active-low reset
//   bus      - seg_reader_if slave modport (SEG in; CODE, VALID, ERR, MATCH, COUNT out)
module seg_reader #(
    parameter int unsigned STABLE_CYCLES = 4  // legal range 1..255
) (
    input  logic       CLOCK_50,
    input  logic [0:0] KEY,
    seg_reader_if.slave bus
);

    localparam logic [7:0]  STABLE    = 8'(STABLE_CYCLES);
    localparam logic [6:0]  PAT_BLANK = 7'h7F;
    localparam logic [15:0] HIST_CLR  = 16'hFFFF;
    localparam logic [15:0] HIST_OLEG = 16'h0123;  // oldest entry in the top nibble

    typedef enum logic [0:0] {StArmed, StHeld} state_e;

    logic rst_n;
    assign rst_n = KEY[0];

    // Input path: 2-flop synchroniser plus stability counter
    logic [6:0] sync1_q, sync2_q;
    logic [7:0] cnt_q, cnt_d;
    logic       qual_q, qual_d;
    logic       change;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= PAT_BLANK;
            sync2_q <= PAT_BLANK;
            cnt_q   <= 8'd0;
            qual_q  <= 1'b0;
        end else begin
            sync1_q <= bus.SEG;
            sync2_q <= sync1_q;
            cnt_q   <= cnt_d;
            qual_q  <= qual_d;
        end
    end

    // The counter tracks how long sync2 has held its value; sync1 is sync2's next value.
    always_comb begin
        change = (sync1_q != sync2_q);
        if (change) begin
            cnt_d = 8'd1;
        end else if (cnt_q >= STABLE) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // Fire only when the count first reaches the threshold; a reload restarts that.
        qual_d = (cnt_d == STABLE) && (change || (cnt_q != STABLE));
    end

    // Character decode of the qualified (stable) pattern
    logic [3:0] dec_code;
    logic       dec_known;
    logic       is_blank;

    always_comb begin
        dec_code  = 4'd0;
        dec_known = 1'b1;
        case (sync2_q)
            7'h40:   dec_code = 4'd0;
            7'h47:   dec_code = 4'd1;
            7'h06:   dec_code = 4'd2;
            7'h42:   dec_code = 4'd3;
            7'h09:   dec_code = 4'd4;
            7'h4F:   dec_code = 4'd5;
            7'h00:   dec_code = 4'd6;
            7'h0C:   dec_code = 4'd7;
            7'h46:   dec_code = 4'd8;
            default: dec_known = 1'b0;
        endcase
        is_blank = (sync2_q == PAT_BLANK);
    end

    // Acceptance FSM and registered outputs
    state_e      state_q, state_d;
    logic [6:0]  last_pat_q, last_pat_d;
    logic [3:0]  code_q, code_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        match_q, match_d;
    logic [7:0]  count_q, count_d;
    logic [15:0] hist_q, hist_d;

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StArmed;
            last_pat_q <= PAT_BLANK;
            code_q     <= 4'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            match_q    <= 1'b0;
            count_q    <= 8'd0;
            hist_q     <= HIST_CLR;
        end else begin
            state_q    <= state_d;
            last_pat_q <= last_pat_d;
            code_q     <= code_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            match_q    <= match_d;
            count_q    <= count_d;
            hist_q     <= hist_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_pat_d = last_pat_q;
        code_d     = code_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;
        count_d    = count_q;
        hist_d     = hist_q;

        if (qual_q) begin
            if (is_blank) begin
                state_d = StArmed;
            end else if (!dec_known) begin
                err_d   = 1'b1;
                hist_d  = HIST_CLR;
                state_d = StArmed;
            end else if ((state_q == StArmed) || (sync2_q != last_pat_q)) begin
                code_d     = dec_code;
                valid_d    = 1'b1;
                hist_d     = {hist_q[11:0], dec_code};
                count_d    = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
                last_pat_d = sync2_q;
                state_d    = StHeld;
            end
        end

        match_d = (hist_d == HIST_OLEG);
    end

    assign bus.CODE  = code_q;
    assign bus.VALID = valid_q;
    assign bus.ERR   = err_q;
    assign bus.MATCH = match_q;
    assign bus.COUNT = count_q;

endmodule

// File: tb/tb_seg_reader.sv
// Bench for seg_reader: directed vector table, hand-written corner sequences and randomized
// segment streams, all checked cycle by cycle against a run-length reference model.
module tb_seg_reader;

    localparam int unsigned S = 4;

    logic       clk = 1'b0;
    logic [0:0] key;

    seg_reader_if bus ();

    seg_reader #(.STABLE_CYCLES(S)) dut (
        .CLOCK_50(clk),
        .KEY     (key),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: sync delay as a queue, debounce as an unbounded run length,
    // history as a queue of codes (front = oldest).
    logic [6:0] pat_tab [9] = '{7'h40, 7'h47, 7'h06, 7'h42, 7'h09, 7'h4F, 7'h00, 7'h0C, 7'h46};
    logic [6:0] m_pipe [$];
    logic [6:0] m_cur;
    int         m_run;
    bit         m_armed;
    logic [6:0] m_last;
    int         m_hist [$];
    int         m_code;
    int         m_count;
    bit         m_valid;
    bit         m_err;

    int seg_valids, seg_errs, first_valid_edge, edge_idx;

    function automatic int lookup(logic [6:0] p);
        for (int i = 0; i < 9; i++) begin
            if (pat_tab[i] == p) return i;
        end
        if (p == 7'h7F) return -2;
        return -1;
    endfunction

    function automatic bit m_match();
        return (m_hist[0] == 0) && (m_hist[1] == 1) && (m_hist[2] == 2) && (m_hist[3] == 3);
    endfunction

    task automatic clear_hist();
        m_hist.delete();
        repeat (4) m_hist.push_back(15);
    endtask

    task automatic model_reset();
        m_pipe.delete();
        m_pipe.push_back(7'h7F);
        m_cur   = 7'h7F;
        m_run   = 0;
        m_armed = 1'b1;
        m_last  = 7'h7F;
        clear_hist();
        m_code  = 0;
        m_count = 0;
        m_valid = 1'b0;
        m_err   = 1'b0;
    endtask

    task automatic model_step(logic [6:0] seg_in);
        int c;
        logic [6:0] nv;
        m_valid = 1'b0;
        m_err   = 1'b0;
        // A run that reached S on the previous edge takes effect now.
        if (m_run == int'(S)) begin
            c = lookup(m_cur);
            if (c == -2) begin
                m_armed = 1'b1;
            end else if (c == -1) begin
                m_err   = 1'b1;
                clear_hist();
                m_armed = 1'b1;
            end else if (m_armed || (m_cur != m_last)) begin
                m_code  = c;
                m_valid = 1'b1;
                m_count = (m_count < 255) ? m_count + 1 : 255;
                void'(m_hist.pop_front());
                m_hist.push_back(c);
                m_armed = 1'b0;
                m_last  = m_cur;
            end
        end
        nv = m_pipe.pop_front();
        m_pipe.push_back(seg_in);
        if (nv == m_cur) begin
            m_run++;
        end else begin
            m_cur = nv;
            m_run = 1;
        end
    endtask

    task automatic check_outputs(string tag);
        checks++;
        if (bus.VALID !== m_valid || bus.ERR !== m_err || bus.CODE !== 4'(m_code) ||
            bus.COUNT !== 8'(m_count) || bus.MATCH !== m_match()) begin
            failures++;
            $display("FAIL %s t=%0t: got valid=%0b err=%0b code=%0d count=%0d match=%0b, want valid=%0b err=%0b code=%0d count=%0d match=%0b",
                     tag, $time, bus.VALID, bus.ERR, bus.CODE, bus.COUNT, bus.MATCH,
                     m_valid, m_err, m_code, m_count, m_match());
        end
    endtask

    task automatic tick(string tag);
        @(posedge clk);
        model_step(bus.SEG);
        #1;
        check_outputs(tag);
        edge_idx++;
        if (bus.VALID === 1'b1) begin
            seg_valids++;
            if (first_valid_edge < 0) first_valid_edge = edge_idx;
        end
        if (bus.ERR === 1'b1) seg_errs++;
    endtask

    // Drops reset mid-cycle, holds it over two edges, releases mid-cycle.
    task automatic do_reset();
        key = 1'b0;
        #1;
        model_reset();
        check_outputs("reset_async");
        repeat (2) begin
            @(posedge clk);
            #1;
            check_outputs("reset_held");
        end
        key = 1'b1;
    endtask

    task automatic apply_seg(logic [6:0] seg, int n, string tag);
        bus.SEG          = seg;
        seg_valids       = 0;
        seg_errs         = 0;
        first_valid_edge = -1;
        edge_idx         = 0;
        repeat (n) tick(tag);
    endtask

    typedef struct {
        bit         rst;
        logic [6:0] seg;
        int         cycles;
        int         nv;
        int         ne;
        int         code;
        int         count;
        bit         match;
    } vec_t;

    vec_t vecs [25];

    initial begin
        logic [6:0] p;
        int         k;
        int         hold;

        // {rst, seg, cycles, valids, errs, code, count, match}
        vecs[0]  = '{1'b1, 7'h40, 12, 1, 0, 0, 1, 1'b0};  // latency
        vecs[1]  = '{1'b0, 7'h7F,  8, 0, 0, 0, 1, 1'b0};
        vecs[2]  = '{1'b0, 7'h47,  8, 1, 0, 1, 2, 1'b0};
        vecs[3]  = '{1'b0, 7'h7F,  8, 0, 0, 1, 2, 1'b0};
        vecs[4]  = '{1'b0, 7'h06,  8, 1, 0, 2, 3, 1'b0};
        vecs[5]  = '{1'b0, 7'h7F,  8, 0, 0, 2, 3, 1'b0};
        vecs[6]  = '{1'b0, 7'h42,  8, 1, 0, 3, 4, 1'b1};  // OLEG complete
        vecs[7]  = '{1'b0, 7'h7F,  8, 0, 0, 3, 4, 1'b1};
        vecs[8]  = '{1'b0, 7'h09,  8, 1, 0, 4, 5, 1'b0};
        vecs[9]  = '{1'b0, 7'h40,  8, 1, 0, 0, 6, 1'b0};  // debounce
        vecs[10] = '{1'b0, 7'h06,  2, 0, 0, 0, 6, 1'b0};
        vecs[11] = '{1'b0, 7'h40,  8, 0, 0, 0, 6, 1'b0};
        vecs[12] = '{1'b0, 7'h47, 20, 1, 0, 1, 7, 1'b0};  // repeats
        vecs[13] = '{1'b0, 7'h7F,  8, 0, 0, 1, 7, 1'b0};
        vecs[14] = '{1'b0, 7'h47,  8, 1, 0, 1, 8, 1'b0};
        vecs[15] = '{1'b0, 7'h46,  8, 1, 0, 8, 9, 1'b0};
        vecs[16] = '{1'b1, 7'h40,  8, 1, 0, 0, 1, 1'b0};  // unknown
        vecs[17] = '{1'b0, 7'h47,  8, 1, 0, 1, 2, 1'b0};
        vecs[18] = '{1'b0, 7'h06,  8, 1, 0, 2, 3, 1'b0};
        vecs[19] = '{1'b0, 7'h42,  8, 1, 0, 3, 4, 1'b1};
        vecs[20] = '{1'b0, 7'h7E,  8, 0, 1, 3, 4, 1'b0};
        vecs[21] = '{1'b0, 7'h40,  8, 1, 0, 0, 5, 1'b0};
        vecs[22] = '{1'b0, 7'h47,  8, 1, 0, 1, 6, 1'b0};
        vecs[23] = '{1'b0, 7'h06,  8, 1, 0, 2, 7, 1'b0};
        vecs[24] = '{1'b0, 7'h42,  8, 1, 0, 3, 8, 1'b1};

        key     = 1'b1;
        bus.SEG = 7'h7F;
        model_reset();
        #2;

        for (int i = 0; i < 25; i++) begin
            if (vecs[i].rst) begin
                bus.SEG = vecs[i].seg;
                do_reset();
            end
            apply_seg(vecs[i].seg, vecs[i].cycles, $sformatf("vec%0d_cycle", i));
            checks++;
            if (seg_valids != vecs[i].nv || seg_errs != vecs[i].ne ||
                bus.CODE !== 4'(vecs[i].code) || bus.COUNT !== 8'(vecs[i].count) ||
                bus.MATCH !== vecs[i].match) begin
                failures++;
                $display("FAIL vec%0d: got valids=%0d errs=%0d code=%0d count=%0d match=%0b, want valids=%0d errs=%0d code=%0d count=%0d match=%0b",
                         i, seg_valids, seg_errs, bus.CODE, bus.COUNT, bus.MATCH,
                         vecs[i].nv, vecs[i].ne, vecs[i].code, vecs[i].count, vecs[i].match);
            end
            if (i == 0) begin
                checks++;
                if (first_valid_edge != int'(S) + 2) begin
                    failures++;
                    $display("FAIL latency: got VALID after edge %0d, want edge %0d",
                             first_valid_edge, S + 2);
                end
            end
        end

        // Reset landing on the cycle the qualification would have fired
        bus.SEG = 7'h40;
        do_reset();
        apply_seg(7'h40, S + 1, "reset_due_pre");
        do_reset();
        checks++;
        if (bus.VALID !== 1'b0 || bus.COUNT !== 8'd0 || bus.CODE !== 4'd0) begin
            failures++;
            $display("FAIL reset_due: got valid=%0b count=%0d code=%0d, want 0 0 0",
                     bus.VALID, bus.COUNT, bus.CODE);
        end
        apply_seg(7'h40, 8, "reset_due_post");
        checks++;
        if (seg_valids != 1 || first_valid_edge != int'(S) + 2) begin
            failures++;
            $display("FAIL reset_due_rehold: got valids=%0d first_edge=%0d, want 1 at %0d",
                     seg_valids, first_valid_edge, S + 2);
        end

        // COUNT saturation: alternate two letters directly
        do_reset();
        for (int i = 0; i < 270; i++) begin
            apply_seg((i % 2 == 0) ? 7'h40 : 7'h47, 6, "saturate");
        end
        checks++;
        if (bus.COUNT !== 8'd255) begin
            failures++;
            $display("FAIL count_saturate: got %0d, want 255", bus.COUNT);
        end

        // Randomized segment streams, including short glitches and occasional resets
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) do_reset();
            k = int'($urandom_range(0, 13));
            if (k < 9) begin
                p = pat_tab[k];
            end else if (k < 12) begin
                p = 7'h7F;
            end else begin
                p = 7'($urandom_range(0, 127));
                while (lookup(p) != -1) p = 7'($urandom_range(0, 127));
            end
            hold = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S - 1))
                                               : int'($urandom_range(S, 12));
            apply_seg(p, hold, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
